// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller:
// scan state enum, blank constants, hex glyph table and the leading-zero
// helper used when LEADING_ZERO_BLANK_EN is defined.
package seg_pkg;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] DIG_OFF = 4'hF;

    // Active-low glyphs, bit0=a .. bit6=g, indexed by hex nibble value
    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // True when digit idx and every higher digit of v are zero (digit 0 never)
    function automatic logic lead_zero(input logic [15:0] v, input logic [1:0] idx);
        logic z;
        z = 1'b0;
        case (idx)
            2'd3:    z = (v[15:12] == 4'h0);
            2'd2:    z = (v[15:8] == 8'h00);
            2'd1:    z = (v[15:4] == 12'h000);
            default: z = 1'b0;
        endcase
        return z;
    endfunction

endpackage

// File: rtl/hex_seg_dec.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_seg_dec
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Table lookup of the glyph for one nibble
    always_comb begin
        seg = GLYPH[nib];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller. A 16-bit value is
// snapshotted on request and only swapped in at frame boundaries (digit 3 ->
// digit 0 wrap), so every frame shows one coherent value. Each digit slot is
// BLANK_CYC dark cycles followed by DIV lit cycles.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        upd,
    output logic        upd_ack,
    output logic [6:0]  seq,
    output logic [3:0]  dig_n,
    output logic        frame
);

    localparam int CNT_MAX = (DIV > BLANK_CYC) ? ((DIV > 2) ? DIV : 2)
                                               : ((BLANK_CYC > 2) ? BLANK_CYC : 2);
    localparam int CW = $clog2(CNT_MAX);
    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);
    // State entered at the start of every slot; SHOW directly when there is no gap
    localparam scan_state_t ENTRY = (BLANK_CYC == 0) ? SHOW : BLANK;

    scan_state_t    st_r, st_s;
    logic [1:0]     idx_r, idx_s;
    logic [CW-1:0]  cnt_r, cnt_s;
    logic           init_r;
    logic           bound_s;

    logic [15:0]    disp_r, disp_s;
    logic [15:0]    stage_r, stage_s;
    logic           pend_r, pend_s;
    logic           load_s;

    logic [3:0]     nib_s;
    logic [6:0]     glyph_s;
    logic           dark_s;
    logic [6:0]     seq_s;
    logic [3:0]     dig_s;

    logic [6:0]     seq_r;
    logic [3:0]     dig_r;
    logic           ack_r;
    logic           frame_r;

    // Scan state register; init_r makes the first cycle after reset a frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_r   <= BLANK;
            idx_r  <= 2'd0;
            cnt_r  <= '0;
            init_r <= 1'b1;
        end else begin
            st_r   <= st_s;
            idx_r  <= idx_s;
            cnt_r  <= cnt_s;
            init_r <= 1'b0;
        end
    end

    // Next-state logic: slot sequencing and frame boundary detection
    always_comb begin
        st_s    = st_r;
        idx_s   = idx_r;
        cnt_s   = cnt_r + CW'(1);
        bound_s = 1'b0;
        if (init_r) begin
            st_s    = ENTRY;
            idx_s   = 2'd0;
            cnt_s   = '0;
            bound_s = 1'b1;
        end else begin
            case (st_r)
                BLANK: begin
                    if (cnt_r == BLANK_LAST) begin
                        st_s  = SHOW;
                        cnt_s = '0;
                    end else begin
                        st_s  = BLANK;
                    end
                end
                SHOW: begin
                    if (cnt_r == DIV_LAST) begin
                        st_s    = ENTRY;
                        cnt_s   = '0;
                        idx_s   = idx_r + 2'd1;
                        bound_s = (idx_r == 2'd3);
                    end else begin
                        st_s    = SHOW;
                    end
                end
                default: begin
                    st_s  = ENTRY;
                    idx_s = 2'd0;
                    cnt_s = '0;
                end
            endcase
        end
    end

    // Snapshot handling: loads only at boundaries, otherwise stage the request
    always_comb begin
        disp_s  = disp_r;
        stage_s = stage_r;
        pend_s  = pend_r;
        load_s  = 1'b0;
        if (bound_s) begin
            load_s = pend_r | upd;
            pend_s = 1'b0;
            if (upd) begin
                disp_s = value;
            end else if (pend_r) begin
                disp_s = stage_r;
            end else begin
                disp_s = disp_r;
            end
        end else if (upd) begin
            stage_s = value;
            pend_s  = 1'b1;
        end else begin
            pend_s  = pend_r;
        end
    end

    // Display, staging and pending registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_r  <= 16'h0000;
            stage_r <= 16'h0000;
            pend_r  <= 1'b0;
        end else begin
            disp_r  <= disp_s;
            stage_r <= stage_s;
            pend_r  <= pend_s;
        end
    end

    // Nibble mux feeding the single shared decoder, driven by next-cycle values
    always_comb begin
        case (idx_s)
            2'd0:    nib_s = disp_s[3:0];
            2'd1:    nib_s = disp_s[7:4];
            2'd2:    nib_s = disp_s[11:8];
            2'd3:    nib_s = disp_s[15:12];
            default: nib_s = 4'h0;
        endcase
    end

    hex_seg_dec u_dec (
        .nib (nib_s),
        .seg (glyph_s)
    );

`ifdef LEADING_ZERO_BLANK_EN
    assign dark_s = lead_zero(disp_s, idx_s);
`else
    assign dark_s = 1'b0;
`endif

    // Output decode from the next state so the registered pins track the FSM
    always_comb begin
        seq_s = SEG_OFF;
        dig_s = DIG_OFF;
        if ((st_s == SHOW) && !dark_s) begin
            seq_s = glyph_s;
            dig_s = ~(4'b0001 << idx_s);
        end else begin
            seq_s = SEG_OFF;
            dig_s = DIG_OFF;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_r   <= SEG_OFF;
            dig_r   <= DIG_OFF;
            ack_r   <= 1'b0;
            frame_r <= 1'b0;
        end else begin
            seq_r   <= seq_s;
            dig_r   <= dig_s;
            ack_r   <= load_s;
            frame_r <= bound_s;
        end
    end

    assign seq     = seq_r;
    assign dig_n   = dig_r;
    assign upd_ack = ack_r;
    assign frame   = frame_r;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Scan controller that time-shares one seven-segment decoder across four digit positions of a multiplexed display. It sits between the key-driven counter logic and the board's segment/anode pins. It snapshots a 16-bit value on request, holds it stable for whole frames, and sequences one digit at a time with a blanking gap between digits to prevent ghosting.

## Interface
- DIV, 50000: clock cycles each digit is lit per slot; ≥1
- BLANK_CYC, 8: clock cycles all digits are dark before each lit period; ≥0 (0 removes the gap)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- value  in  16  four hex nibbles; digit i = value[4i+3:4i]
- upd  in  1  single-cycle request to load `value` for display
- upd_ack  out  1  one-cycle pulse when a requested value becomes the displayed value
- seq  out  7  active-low segments, bit0=a … bit6=g
- dig_n  out  4  active-low digit enables, dig_n[i] selects digit i
- frame  out  1  one-cycle pulse at the start of each frame (digit 0 BLANK entry)

## Operation
- Reset values: state BLANK, digit index 0, cycle counter 0, display reg 0, staging reg 0, pending 0. Outputs: seq=7'h7F, dig_n=4'hF, upd_ack=0, frame=0.
- FSM states:
  - BLANK: dig_n=4'hF, seq=7'h7F. Runs BLANK_CYC cycles, then goes to SHOW. With BLANK_CYC=0, BLANK is skipped and SHOW follows SHOW directly.
  - SHOW: dig_n has only bit idx low; seq = glyph(display nibble idx). Runs DIV cycles, then idx←idx+1 (mod 4) and state goes to BLANK.
- Frame boundary: the cycle where idx wraps 3→0.
  - If pending is set, or upd is high in that cycle, the display reg loads. On the following cycle upd_ack=1, frame=1, and pending is cleared.
  - If upd and the boundary coincide, the display reg takes `value` directly, bypassing staging.
  - frame pulses every frame, whether or not a load occurred.
- upd outside a boundary: staging←value, pending←1. A second upd before the boundary overwrites staging; only the last value is shown, with one upd_ack.
- Display reg never changes mid-frame; all four digits of a frame come from one snapshot.
- Glyphs are standard active-low hex:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Cycle counter width is $clog2(max(DIV,BLANK_CYC,2)). The counter resets to 0 on every state change.
- Reset asserted mid-operation returns everything to reset values immediately. Any pending update is discarded, with no upd_ack.

## Timing
- seq, dig_n, upd_ack and frame are all registered; no combinational path from inputs to outputs.
- Slot = BLANK_CYC + DIV cycles. Frame = 4 × slot.
- First frame pulse comes 1 cycle after rst_n deasserts.
- After a boundary load, new digit-0 data appears on seq at the first SHOW cycle of digit 0.
- Worst-case latency from upd to display is one frame + 1 cycle.

## Configuration
- LEADING_ZERO_BLANK_EN defined: digit i (i=3..1) is suppressed when its nibble and all higher nibbles are 0. A suppressed digit has dig_n bit i=1 and seq=7'h7F during its SHOW, with unchanged slot timing. Digit 0 is always shown.
- LEADING_ZERO_BLANK_EN undefined: all four digits always shown, leading zeros included.

## Structure
- Shared package seg_pkg holds:
  - state enum {BLANK, SHOW}
  - SEG_OFF=7'h7F, DIG_OFF=4'hF
  - 16-entry glyph constant array
- One sub-module: hex_seg_dec (4-bit nibble → 7-bit active-low glyph, combinational, from the package array). Instantiated once and fed by the nibble mux.

## Test plan
All scenarios use DIV=4, BLANK_CYC=2 (slot 6, frame 24) unless stated.
- Reset: hold rst_n=0 → seq=7'h7F, dig_n=4'hF, upd_ack=0. Release → frame pulses at cycle 1, then every 24 cycles.
- Load: upd with value=16'h12AF, then wait for the boundary → upd_ack pulses once. Next frame shows, in SHOW order:
  - dig_n=1110 with seq=0001110
  - dig_n=1101 with seq=0001000
  - dig_n=1011 with seq=0100100
  - dig_n=0111 with seq=1111001
- Mid-frame defer: with 16'h1111 displayed, pulse upd=16'h2222 during digit 2 SHOW → digits 2 and 3 still show 1 this frame; all show 2 next frame; one upd_ack.
- Boundary coincidence and overwrite:
  - upd=16'h0005 in the exact wrap cycle → next frame shows 0005.
  - Two upds (16'h0003, then 16'h0007) in one frame → 0007 shown, single upd_ack.
- Leading zero (macro on), value 16'h0040 → digits 3 and 2 dark (dig_n bit high, seq 7F); digit 1 = 0011001; digit 0 = 1000000. With the macro off, digits 3 and 2 show 1000000.
- Reset mid-operation: assert rst_n during digit 1 SHOW with pending set → outputs go dark immediately; after release, display shows 0000 and no upd_ack.
